// File: rtl/latency_data_mem.sv
// latency_data_mem: word-addressed 32-bit data memory with a fixed access latency,
// completing one read or write per cs/ack handshake and exposing its FSM state.
module latency_data_mem #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        ack,
    output logic        stall,
    output logic [2:0]  ram_state
);
    typedef enum logic [2:0] {IDLE = 3'd0, READ = 3'd1, WRITE = 3'd2, ACK = 3'd3} state_t;
    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           din_q, din_d, dout_q;
    logic [31:0]           mem_q [2**ADDR_WIDTH];
    logic                  done;
    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_WIDTH+2], addr[1:0]};
    assign done = cnt_q == 4'd0;
    // The access direction is carried by the state itself, so we needs no latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        din_d   = din_q;
        case (state_q)
            IDLE: if (cs) begin
                state_d = we ? WRITE : READ;
                cnt_d   = 4'(LATENCY - 1);
                addr_d  = addr[ADDR_WIDTH+1:2];
                din_d   = din;
            end
            READ, WRITE: begin
                state_d = done ? ACK : state_q;
                cnt_d   = done ? cnt_q : cnt_q - 4'd1;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end
    // Array port kept free of reset so it maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (!rst && state_q == WRITE && done) mem_q[addr_q] <= din_q;
    end
    always_ff @(posedge clk) begin
        if (rst) dout_q <= '0;
        else if (state_q == READ && done) dout_q <= mem_q[addr_q];
    end
    assign dout      = dout_q;
    assign ack       = state_q == ACK;
    assign stall     = state_q != IDLE;
    assign ram_state = state_q;
endmodule

// File: tb/tb_latency_data_mem.sv
// tb_latency_data_mem: scoreboard bench for latency_data_mem with LATENCY=4 and LATENCY=1
// instances; a word-indexed reference memory supplies expected read data.
module tb_latency_data_mem;
    logic        clk = 1'b0, rst;
    logic        cs, we, ack, stall;
    logic [31:0] addr, din, dout;
    logic [2:0]  st;
    logic        cs1, we1, ack1, stall1;
    logic [31:0] addr1, din1, dout1;
    logic [2:0]  st1;
    int          tests = 0, fails = 0, cyc = 0;
    logic [31:0] model [int];
    logic [31:0] exp_q [$];

    latency_data_mem #(.ADDR_WIDTH(10), .LATENCY(4)) dut0 (
        .clk(clk), .rst(rst), .cs(cs), .we(we), .addr(addr), .din(din),
        .dout(dout), .ack(ack), .stall(stall), .ram_state(st));
    latency_data_mem #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk(clk), .rst(rst), .cs(cs1), .we(we1), .addr(addr1), .din(din1),
        .dout(dout1), .ack(ack1), .stall(stall1), .ram_state(st1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Drives one request at a negedge; returns at the negedge after acceptance.
    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, output int acc);
        int idx = int'(a[11:2]);
        cs = 1'b1; we = w; addr = a; din = d;
        @(negedge clk);
        acc = cyc;
        cs = 1'b0; we = ~w; addr = ~a; din = ~d;
        if (w) model[idx] = d;
        else exp_q.push_back(model[idx]);
    endtask

    task automatic wait_ack(input int acc, output int lat);
        lat = -1;
        for (int i = 0; i < 40 && lat < 0; i++) begin
            if (ack) lat = cyc - acc;
            else @(negedge clk);
        end
    endtask

    // Full transaction; exp is the scoreboard value for reads, prior dout for writes.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] got, output logic [31:0] exp);
        int acc;
        logic [31:0] prev = dout;
        issue(w, a, d, acc);
        wait_ack(acc, lat);
        got = dout;
        exp = w ? prev : exp_q.pop_front();
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; din = '0;
        cs1 = 1'b0; we1 = 1'b0; addr1 = '0; din1 = '0;
        repeat (2) @(negedge clk);
        tests++; if (ack !== 1'b0) begin fails++; $display("FAIL reset_ack: got %b expected 0", ack); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %b expected 0", stall); end
        tests++; if (dout !== 32'h0) begin fails++; $display("FAIL reset_dout: got %h expected 0", dout); end
        tests++; if (st !== 3'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", st); end
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (st !== 3'd0 || ack !== 1'b0) begin fails++; $display("FAIL idle_hold: state %0d ack %b expected 0/0", st, ack); end
        end
    endtask

    task automatic test_write_read;
        int acc, lat;
        logic [31:0] got, exp;
        issue(1'b1, 32'h10, 32'hDEADBEEF, acc);
        for (int i = 0; i < 4; i++) begin
            tests++; if (st !== 3'd2 || ack !== 1'b0) begin fails++; $display("FAIL write_state_%0d: state %0d ack %b expected 2/0", i, st, ack); end
            @(negedge clk);
        end
        wait_ack(acc, lat);
        tests++; if (lat !== 4) begin fails++; $display("FAIL write_latency: got %0d expected 4", lat); end
        @(negedge clk);
        tests++; if (ack !== 1'b0 || st !== 3'd0) begin fails++; $display("FAIL ack_pulse: ack %b state %0d expected 0/0", ack, st); end
        do_txn(1'b0, 32'h10, 32'h0, lat, got, exp);
        tests++; if (lat !== 4) begin fails++; $display("FAIL read_latency: got %0d expected 4", lat); end
        tests++; if (got !== exp) begin fails++; $display("FAIL read_data: got %h expected %h", got, exp); end
    endtask

    task automatic test_alias;
        int lat;
        logic [31:0] got, exp;
        do_txn(1'b1, 32'h13, 32'h12345678, lat, got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL write_keeps_dout: got %h expected %h", got, exp); end
        do_txn(1'b0, 32'h10, 32'h0, lat, got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL alias_low_bits: got %h expected %h", got, exp); end
        do_txn(1'b0, 32'h1010, 32'h0, lat, got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL alias_high_bits: got %h expected %h", got, exp); end
    endtask

    task automatic test_back_to_back;
        int acks [$];
        int idle_cnt = 0, stall_bad = 0;
        logic [31:0] got = '0, exp;
        cs = 1'b1; we = 1'b1; addr = 32'h40; din = 32'hA5A50F0F;
        model[16] = 32'hA5A50F0F;
        exp_q.push_back(model[16]);
        @(negedge clk);
        we = 1'b0; din = 32'h0;
        for (int i = 0; i < 40 && acks.size() < 2; i++) begin
            if (stall !== (st != 3'd0)) stall_bad++;
            if (st == 3'd0) idle_cnt++;
            if (ack) begin
                acks.push_back(cyc);
                if (acks.size() == 2) begin got = dout; cs = 1'b0; end
            end
            @(negedge clk);
        end
        exp = exp_q.pop_front();
        tests++;
        if (acks.size() != 2) begin fails++; $display("FAIL b2b_acks: got %0d acks expected 2", acks.size()); end
        else if (acks[1] - acks[0] != 6) begin fails++; $display("FAIL b2b_spacing: got %0d expected 6", acks[1] - acks[0]); end
        tests++; if (got !== exp) begin fails++; $display("FAIL b2b_data: got %h expected %h", got, exp); end
        tests++; if (idle_cnt != 1 || stall_bad != 0) begin fails++; $display("FAIL b2b_stall: idle %0d bad %0d expected 1/0", idle_cnt, stall_bad); end
    endtask

    task automatic test_reset_mid;
        int lat, ack_seen = 0;
        logic [31:0] got, exp;
        do_txn(1'b1, 32'h20, 32'h11111111, lat, got, exp);
        do_txn(1'b0, 32'h20, 32'h0, lat, got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL pre_reset_read: got %h expected %h", got, exp); end
        cs = 1'b1; we = 1'b1; addr = 32'h20; din = 32'hCAFEF00D;
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        tests++; if (st !== 3'd2) begin fails++; $display("FAIL mid_state: got %0d expected 2", st); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++; if (st !== 3'd0 || ack !== 1'b0 || stall !== 1'b0) begin fails++; $display("FAIL mid_reset_ctrl: state %0d ack %b stall %b expected 0/0/0", st, ack, stall); end
        tests++; if (dout !== 32'h0) begin fails++; $display("FAIL mid_reset_dout: got %h expected 0", dout); end
        for (int i = 0; i < 6; i++) begin
            if (ack) ack_seen++;
            @(negedge clk);
        end
        tests++; if (ack_seen != 0) begin fails++; $display("FAIL mid_reset_noack: got %0d acks expected 0", ack_seen); end
        do_txn(1'b0, 32'h20, 32'h0, lat, got, exp);
        tests++; if (got !== exp) begin fails++; $display("FAIL abandoned_write: got %h expected %h", got, exp); end
    endtask

    task automatic test_latency1;
        logic [31:0] exp;
        cs1 = 1'b1; we1 = 1'b1; addr1 = 32'h8; din1 = 32'h55AA33CC;
        @(negedge clk);
        cs1 = 1'b0; din1 = 32'h0;
        tests++; if (st1 !== 3'd2) begin fails++; $display("FAIL l1_write_state: got %0d expected 2", st1); end
        @(negedge clk);
        tests++; if (ack1 !== 1'b1) begin fails++; $display("FAIL l1_write_ack: got %b expected 1", ack1); end
        @(negedge clk);
        tests++; if (ack1 !== 1'b0) begin fails++; $display("FAIL l1_ack_pulse: got %b expected 0", ack1); end
        exp_q.push_back(32'h55AA33CC);
        cs1 = 1'b1; we1 = 1'b0; addr1 = 32'h8;
        @(negedge clk);
        cs1 = 1'b0;
        tests++; if (st1 !== 3'd1) begin fails++; $display("FAIL l1_read_state: got %0d expected 1", st1); end
        @(negedge clk);
        exp = exp_q.pop_front();
        tests++; if (ack1 !== 1'b1 || dout1 !== exp) begin fails++; $display("FAIL l1_read: ack %b dout %h expected 1/%h", ack1, dout1, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_alias;
        test_back_to_back;
        test_reset_mid;
        test_latency1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d tests run", tests);
        $fatal(1);
    end
endmodule
